// File: rtl/router_ingress_fifo_if.sv
// router_ingress_fifo_if: producer-side and router-side signals of the ingress FIFO
//   in_data/in_addr/in_valid -> FIFO, in_ready <- FIFO   (producer handshake)
//   out_ready -> FIFO, din/din_en/addr/count <- FIFO      (router side)
interface router_ingress_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    logic [DATA_WIDTH-1:0]      in_data;
    logic [1:0]                 in_addr;
    logic                       in_valid;
    logic                       in_ready;
    logic                       out_ready;
    logic [DATA_WIDTH-1:0]      din;
    logic                       din_en;
    logic [1:0]                 addr;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_data, in_addr, in_valid, out_ready,
        input  in_ready, din, din_en, addr, count
    );

    modport slave (
        input  in_data, in_addr, in_valid, out_ready,
        output in_ready, din, din_en, addr, count
    );
endinterface

// File: rtl/router_ingress_fifo.sv
// router_ingress_fifo: show-ahead FIFO of {addr, data} words feeding the 4-port address router
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of router_ingress_fifo_if (producer handshake in, router head out)
module router_ingress_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input logic                  clk,
    input logic                  resetn,
    router_ingress_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH+1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count_q;
    logic                  push;
    logic                  pop;

    // Outputs depend only on registered state, so in_valid/out_ready never reach them combinationally.
    assign bus.in_ready = resetn && (count_q != CW'(DEPTH));
    assign bus.din_en   = count_q != '0;
    assign bus.din      = bus.din_en ? mem[rd_ptr][DATA_WIDTH-1:0] : '0;
    assign bus.addr     = bus.din_en ? mem[rd_ptr][DATA_WIDTH+1:DATA_WIDTH] : '0;
    assign bus.count    = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.din_en && bus.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage is don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.in_addr, bus.in_data};
    end
endmodule

// File: doc/router_ingress_fifo.md
Name: router_ingress_fifo

Overview:
Ingress buffer that sits directly upstream of the 4-port address router. It accepts {addr, data} words from a producer over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents the head entry to the router as din/din_en/addr, one word per transfer. A downstream out_ready stall lets the router side hold traffic without losing words.

Parameters:
DATA_WIDTH, 32, width of the data payload (matches router din width)
DEPTH, 8, number of FIFO entries; power of 2, minimum 2

Ports:
clk  input  1  single clock; all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
in_data  input  DATA_WIDTH  payload from producer
in_addr  input  2  destination port (0..3) for in_data
in_valid  input  1  producer has a word
in_ready  output  1  FIFO can accept a word this cycle
out_ready  input  1  router side accepts the presented word this cycle
din  output  DATA_WIDTH  head payload to router
din_en  output  1  head entry valid
addr  output  2  head destination to router
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {addr[1:0], data}. Read and write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in count.
- Reset (resetn low, async): pointers=0, count=0, din_en=0, din=0, addr=0. in_ready is forced 0 while resetn is low. Storage contents are don't-care.
- in_ready = resetn && (count != DEPTH). It is combinational from registered count only, with no dependence on out_ready.
- Push: occurs on a clk edge when in_valid && in_ready. Writes {in_addr, in_data} at the write pointer, then increments the write pointer.
- Pop: occurs on a clk edge when din_en && out_ready. Increments the read pointer.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Output (show-ahead): din_en = (count != 0).
  - When din_en=1: din/addr = head entry at the read pointer.
  - When din_en=0: din=0 and addr=0. This keeps the router outputs at zero.
- Latency: a word pushed into an empty FIFO at edge N appears on din/addr with din_en=1 immediately after edge N, i.e. in the cycle following acceptance. There is no same-cycle bypass from in_* to din.
- Stall: while din_en=1 and out_ready=0, din, addr and din_en hold stable across edges. Pushes still proceed if in_ready=1.
- Full: count=DEPTH gives in_ready=0. A push is not accepted even if a pop happens in the same cycle; in_ready rises the cycle after the pop.
- Empty: out_ready is ignored when din_en=0, and no pointer moves.
- Ordering: strict FIFO across all destinations. No reordering by addr, and no head-of-line bypass.
- Reset mid-operation: all queued words are discarded. din_en falls asynchronously with resetn. After release, the first accepted word is the next one pushed.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
1. Reset, then push (addr=2, data=0xA5A5_0001) with out_ready=0 -> next cycle din_en=1, addr=2, din=0xA5A50001, count=1. These values hold for 3 stalled cycles.
2. DEPTH=8: push 8 words (data 1..8, addr = i%4) with out_ready=0 -> count=8, in_ready=0. A 9th word held valid is not accepted. Then out_ready=1 -> words pop in order 1..8 with matching addr; din_en=0 and din=0 after the last.
3. Full plus simultaneous in_valid and out_ready -> that cycle pops only (count 8->7). The next cycle push and pop together leave count=7.
4. Continuous streaming with in_valid=1 and out_ready=1 from empty -> after a 1-cycle fill, one word per cycle. count stays 1 and ordering is preserved across pointer wrap (over 20 words).
5. Assert resetn low mid-stream with count=5 -> din_en=0, din=0, addr=0 and in_ready=0 immediately. After release count=0, and a new push (addr=3, data=0x1234) is the first word out.
6. Empty FIFO with out_ready toggling and in_valid=0 -> din_en stays 0, count stays 0, and pointers do not move (a subsequent push emerges correctly).
